// File: rtl/pe_arr_drain.sv
// pe_arr_drain -- result drain for the systolic PE array.
//
// When cap is accepted, the whole accumulator bus is snapshotted. Each element
// is saturated to OUT_W at that point. The elements are then streamed out one
// per valid/ready handshake, in row-major order.
//
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous reset, active HIGH (despite the name)
//   cap        capture pulse; snapshot res_port this cycle
//   res_port   ascending bus [0:ACC_W*N-1]; element k = [ACC_W*k : ACC_W*(k+1)-1]
//   out_valid  out_* carry a valid element
//   out_ready  downstream accept
//   out_data   saturated signed element
//   out_row    row index of current element
//   out_col    column index of current element
//   out_last   current element is the last of the tile
//   busy       high while streaming (same as out_valid)
//   overrun    sticky; a cap arrived while busy and was dropped

// Signed saturation of one accumulator to OUT_W bits.
module pe_drain_sat #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
) (
    input  logic [ACC_W-1:0] acc,
    output logic [OUT_W-1:0] sat
);
    generate
        if (OUT_W == ACC_W) begin : g_pass
            assign sat = acc;
        end else begin : g_sat
            // In range iff every bit above the output sign bit copies the sign.
            logic hi_same;
            assign hi_same = (acc[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){acc[ACC_W-1]}});
            always_comb begin
                sat = acc[OUT_W-1:0];
                if (!hi_same)
                    sat = acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    endgenerate
endmodule

module pe_arr_drain #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        cap,
    input  logic [0:ACC_W*ROWS*COLS-1]  res_port,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_W-1:0]            out_data,
    output logic [RW-1:0]               out_row,
    output logic [CW-1:0]               out_col,
    output logic                        out_last,
    output logic                        busy,
    output logic                        overrun
);
    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  state_q, state_d;
    logic [N-1:0][OUT_W-1:0] sat_all;   // saturated view of the live bus
    logic [N-1:0][OUT_W-1:0] tile_q;    // snapshot being drained
    logic [IW-1:0]           idx_q, idx_nxt;
    logic                    load, adv, drop;

    // Saturation happens at capture time, so the buffer only needs OUT_W bits.
    generate
        for (genvar k = 0; k < N; k++) begin : g_lane
            pe_drain_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat (
                .acc (res_port[ACC_W*k +: ACC_W]),
                .sat (sat_all[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap) begin
                    load    = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (out_last) begin
                        // A cap on the final transfer starts the next tile with no bubble.
                        if (cap) load    = 1'b1;
                        else     state_d = IDLE;
                    end else begin
                        adv = 1'b1;
                    end
                end
                if (cap && !(out_ready && out_last)) drop = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign idx_nxt   = idx_q + 1'b1;
    assign out_valid = (state_q == STREAM);
    assign busy      = out_valid;

    // The buffer is never reset; its contents are meaningless until a capture.
    always_ff @(posedge clk) begin
        if (load) tile_q <= sat_all;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            idx_q    <= '0;
            out_row  <= '0;
            out_col  <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (load) begin
                idx_q    <= '0;
                out_row  <= '0;
                out_col  <= '0;
                out_data <= sat_all[0];
                out_last <= (N == 1);
            end else if (adv) begin
                idx_q    <= idx_nxt;
                out_data <= tile_q[idx_nxt];
                out_last <= (idx_nxt == IW'(N-1));
                if (out_col == CW'(COLS-1)) begin
                    out_col <= '0;
                    out_row <= out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end else if (state_d == IDLE) begin
                out_last <= 1'b0;
            end
            if (drop) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pe_arr_drain.sv
// Self-checking bench for pe_arr_drain (default parameters).
// Reference model: a queue of pending {data,row,col,last} records.
// A tile is pushed when the model accepts a cap, and the front record is
// popped on each handshake.
module tb_pe_arr_drain;
    localparam int ROWS = 4, COLS = 4, ACC_W = 32, OUT_W = 16;
    localparam int N = ROWS * COLS;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b1;
    logic                 cap = 1'b0;
    logic [0:ACC_W*N-1]   res_port = '0;
    logic                 out_valid, out_ready = 1'b0;
    logic [OUT_W-1:0]     out_data;
    logic [1:0]           out_row, out_col;
    logic                 out_last, busy, overrun;

    pe_arr_drain #(.ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rstn(rstn), .cap(cap), .res_port(res_port),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          row;
        int          col;
        logic        last;
    } elem_t;

    typedef struct {
        logic [31:0] acc;
        logic [15:0] exp;
    } sat_vec_t;

    elem_t    q[$];
    logic     m_ovr = 1'b0;
    int       n_chk = 0, n_fail = 0;
    sat_vec_t tbl[N];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [31:0] v);
        longint s;
        s = longint'($signed(v));
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    task automatic set_elem(input int k, input logic [31:0] v);
        res_port[k*ACC_W +: ACC_W] = v;
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, q.size() > 0);
        chk("busy", busy, q.size() > 0);
        chk("overrun", overrun, m_ovr);
        if (q.size() > 0) begin
            chk("out_data", out_data, q[0].data);
            chk("out_row", out_row, q[0].row);
            chk("out_col", out_col, q[0].col);
            chk("out_last", out_last, q[0].last);
        end else begin
            chk("out_last_idle", out_last, 0);
        end
    endtask

    // Check the current outputs, drive cap/ready, advance the model, then clock.
    task automatic step(input logic c, input logic r);
        logic acc_now;
        check_outputs();
        cap = c;
        out_ready = r;
        acc_now = c && (q.size() == 0 || (q.size() == 1 && r));
        if (c && !acc_now) m_ovr = 1'b1;
        if (q.size() > 0 && r) void'(q.pop_front());
        if (acc_now)
            for (int k = 0; k < N; k++)
                q.push_back('{sat16(res_port[k*ACC_W +: ACC_W]), k / COLS, k % COLS, k == N-1});
        @(posedge clk);
        #1;
        cap = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (q.size() > 0 && n < limit) begin
            step(1'b0, 1'b1);
            n++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        int cyc, stalls, vcnt;

        // Reset state
        #12 rstn = 1'b0;
        @(posedge clk); #1;
        chk("rst_data", out_data, 0);
        chk("rst_row", out_row, 0);
        chk("rst_col", out_col, 0);
        check_outputs();

        // Basic drain: element k = k*0x10, ready held high
        for (int k = 0; k < N; k++) set_elem(k, 32'(k * 16));
        step(1'b1, 1'b1);
        vcnt = 0;
        for (int t = 1; t <= N + 1; t++) begin
            if (out_valid) vcnt++;
            if (t == N) chk("basic_last_t16", out_last, 1);
            step(1'b0, 1'b1);
        end
        chk("basic_valid_cycles", vcnt, N);

        // Saturation table
        tbl[0] = '{32'h00012345, 16'h7FFF};
        tbl[1] = '{32'hFFFF8000, 16'h8000};
        tbl[2] = '{32'hFFFE0000, 16'h8000};
        tbl[3] = '{32'h00007FFF, 16'h7FFF};
        tbl[4] = '{32'hFFFFFFFF, 16'hFFFF};
        tbl[5] = '{32'h00008000, 16'h7FFF};
        tbl[6] = '{32'hFFFF7FFF, 16'h8000};
        tbl[7] = '{32'h80000000, 16'h8000};
        for (int k = 8; k < N; k++) tbl[k] = '{32'(k * 3 - 20), 16'(k * 3 - 20)};
        for (int k = 0; k < N; k++) set_elem(k, tbl[k].acc);
        step(1'b1, 1'b1);
        for (int k = 0; k < N; k++) begin
            chk("sat_table", out_data, tbl[k].exp);
            step(1'b0, 1'b1);
        end
        step(1'b0, 1'b1);

        // Backpressure: ready 1,0,0,1 repeating
        for (int k = 0; k < N; k++) set_elem(k, $urandom);
        step(1'b1, 1'b0);
        cyc = 0; stalls = 0;
        while (out_valid && cyc < 200) begin
            if (cyc % 4 == 1 || cyc % 4 == 2) stalls++;
            step(1'b0, !(cyc % 4 == 1 || cyc % 4 == 2));
            cyc++;
        end
        chk("bp_total_cycles", cyc, N + stalls);

        // Overrun at element 4, back-to-back cap on the last transfer
        for (int k = 0; k < N; k++) set_elem(k, 32'(k + 100));
        step(1'b1, 1'b1);
        for (int t = 0; t < 4; t++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("ovr_set", overrun, 1);
        for (int k = 0; k < N; k++) set_elem(k, 32'(k + 500));
        cyc = 0;
        while (q.size() > 1 && cyc < 50) begin step(1'b0, 1'b1); cyc++; end
        step(1'b1, 1'b1);
        chk("b2b_no_gap", out_valid, 1);
        chk("b2b_elem0", out_data, 500);
        // Snapshot isolation: the bus changes every cycle while draining
        cyc = 0;
        while (q.size() > 0 && cyc < 50) begin
            for (int k = 0; k < N; k++) set_elem(k, $urandom);
            step(1'b0, 1'b1);
            cyc++;
        end
        chk("ovr_sticky", overrun, 1);

        // Reset mid-stream at element 7
        for (int k = 0; k < N; k++) set_elem(k, 32'(k * 7));
        step(1'b1, 1'b1);
        for (int t = 0; t < 7; t++) step(1'b0, 1'b1);
        chk("pre_rst_row", out_row, 1);
        #2 rstn = 1'b1;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_ovr", overrun, 0);
        q.delete();
        m_ovr = 1'b0;
        @(posedge clk); #2 rstn = 1'b0;
        @(posedge clk); #1;
        step(1'b1, 1'b1);
        drain(50);
        step(1'b0, 1'b1);

        // Random traffic against the model
        for (int t = 0; t < 3000; t++) begin
            for (int k = 0; k < N; k++)
                set_elem(k, ($urandom_range(0, 1) != 0) ? $urandom
                                                       : 32'($signed(16'($urandom))));
            step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        end
        drain(200);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_arr_drain.md
# pe_arr_drain

Result drain for the systolic PE array. On a capture pulse it snapshots the array's flattened accumulator bus into a local buffer. It then streams the elements out one per handshake, in row-major order, over a valid/ready interface, saturating each accumulator to the output width. It sits between the PE array result port and the downstream writeback/memory path, freeing the array to start the next tile while results drain.

## Interface
- ROWS, 4, PE array rows
- COLS, 4, PE array columns
- ACC_W, 32, accumulator width per PE on the array result bus
- OUT_W, 16, output element width (OUT_W <= ACC_W); signed saturation applied
- clk  in  1  clock; all state on rising edge
- rstn  in  1  reset, asynchronous, active-high (asserted = 1 despite the name)
- cap  in  1  capture pulse; snapshot res_port this cycle
- res_port  in  ACC_W*ROWS*COLS  array results, ascending-bit bus [0:ACC_W*ROWS*COLS-1]; element k = bits [ACC_W*k : ACC_W*(k+1)-1], k = row*COLS + col
- out_valid  out  1  out_data/out_row/out_col/out_last are valid
- out_ready  in  1  downstream accepts when high with out_valid
- out_data  out  OUT_W  saturated signed element
- out_row  out  clog2(ROWS) (min 1)  row index of current element
- out_col  out  clog2(COLS) (min 1)  column index of current element
- out_last  out  1  current element is k = ROWS*COLS-1
- busy  out  1  high while in STREAM
- overrun  out  1  sticky; cap arrived while busy and was dropped

## Operation
- States: IDLE, STREAM.
- IDLE: out_valid=0. On cap=1, latch all ROWS*COLS elements into the buffer, set k=0, and go to STREAM.
- STREAM: out_valid=1, and outputs present element k. A transfer occurs when out_valid && out_ready.
  - On a transfer with k < N-1 (N=ROWS*COLS): k <= k+1.
  - On a transfer with k = N-1: return to IDLE, unless cap=1 in that same cycle. In that case, recapture, set k=0, and stay in STREAM (back-to-back tiles, no bubble).
- cap in STREAM, other than on the final transfer cycle: ignored, buffer unchanged, overrun <= 1.
- overrun clears only on reset.
- Saturation: the element is treated as signed ACC_W.
  - If value > 2^(OUT_W-1)-1, out_data = 2^(OUT_W-1)-1.
  - If value < -2^(OUT_W-1), out_data = -2^(OUT_W-1).
  - Otherwise, out_data = low OUT_W bits.
  - With OUT_W = ACC_W, out_data passes through unchanged.
- out_row = k / COLS and out_col = k % COLS. Implement these with row/col counters (col wraps at COLS-1 and increments row), not a divider.
- While out_valid && !out_ready, all out_* hold stable.
- res_port is sampled only on an accepted cap; later changes do not affect buffered data.

## Timing
- Reset values: out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0, overrun=0, state=IDLE, buffer contents don't-care.
- Reset asserted mid-stream aborts immediately: outputs go to reset values asynchronously, and no further transfers occur.
- Latency: cap in cycle t puts element 0 on the outputs with out_valid=1 in cycle t+1.
- Throughput: 1 element/cycle with out_ready held high. A tile takes exactly N cycles of out_valid.
- out_valid falls in the cycle after the last transfer (unless a back-to-back cap occurs).
- busy equals out_valid.
- out_last is registered alongside out_data. It is high only while element N-1 is presented.
- Outputs are registered. There is no combinational path from out_ready or cap to any output.

## Test plan
- Basic drain, default params, out_ready=1: res_port element k = k*0x10.
  - cap at t=0 → out_valid high t=1..16.
  - out_data = 0x0000, 0x0010, ..., 0x00F0 in row-major order.
  - (row,col) runs (0,0) … (3,3).
  - out_last only at t=16; out_valid=0 at t=17.
- Backpressure: out_ready toggles 1,0,0,1,… → each element is held stable while ready=0. All 16 elements arrive exactly once and in order, and the total cycles equal 16 plus the number of stall cycles.
- Saturation, OUT_W=16:
  - element 0 = 0x00012345 → 0x7FFF
  - element 1 = 0xFFFF8000 → 0x8000
  - element 2 = 0xFFFE0000 → 0x8000
  - element 3 = 0x00007FFF → 0x7FFF
  - element 4 = 0xFFFFFFFF → 0xFFFF
- Overrun and back-to-back:
  - cap at the 5th element → ignored, overrun=1, stream unchanged.
  - cap on the cycle of the last transfer → new tile element 0 presented the next cycle with no out_valid gap.
  - overrun stays 1.
- Snapshot isolation: change res_port every cycle after cap → the streamed values equal the values present at the cap cycle.
- Reset mid-stream: assert rstn at element 7 → out_valid, busy, and overrun drop to 0 asynchronously. After release, a new cap streams from element 0 correctly.
